// File: rtl/barrel_pkg.sv
// -----------------------------------------------------------------------------
// barrel_pkg
// Shared definitions for the rotate unit: the direction field type and its
// two encodings. Imported by barrel_rotate_core and barrel_shifter_top.
// -----------------------------------------------------------------------------
package barrel_pkg;

  // Direction field of a rotate request.
  typedef logic dir_t;

  localparam dir_t DIR_LEFT  = 1'b0;
  localparam dir_t DIR_RIGHT = 1'b1;

endpackage : barrel_pkg

// File: rtl/barrel_rotate_core.sv
// -----------------------------------------------------------------------------
// barrel_rotate_core
// Purely combinational circular rotate of a WIDTH-bit word, built as a
// logarithmic network of SHAMT_WIDTH stages. Stage i rotates by 2^i when
// shamt[i] is set and passes the word through otherwise. Each stage picks
// the left or right form of its fixed rotation, so the composite is a
// rotation by shamt in the requested direction.
//
// Ports:
//   a_in   in  WIDTH        word to rotate
//   shamt  in  SHAMT_WIDTH  rotate amount, 0..WIDTH-1
//   dir    in  1            DIR_LEFT / DIR_RIGHT
//   rot    out WIDTH        rotated word
// -----------------------------------------------------------------------------
module barrel_rotate_core
  import barrel_pkg::*;
#(
  parameter  int WIDTH       = 16,
  localparam int SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]       a_in,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  dir_t                   dir,
  output logic [WIDTH-1:0]       rot
);

  // stage_s[0] is the input word; stage_s[i+1] is the output of stage i.
  logic [SHAMT_WIDTH:0][WIDTH-1:0] stage_s;

  assign stage_s[0] = a_in;

  for (genvar i = 0; i < SHAMT_WIDTH; i++) begin : g_stage
    // Every step is strictly less than WIDTH, so no shift by WIDTH is formed
    // and every slice below is non-empty.
    localparam int STEP = 1 << i;

    logic [WIDTH-1:0] rotl_s;
    logic [WIDTH-1:0] rotr_s;

    assign rotl_s = {stage_s[i][WIDTH-1-STEP:0], stage_s[i][WIDTH-1:WIDTH-STEP]};
    assign rotr_s = {stage_s[i][STEP-1:0],       stage_s[i][WIDTH-1:STEP]};

    assign stage_s[i+1] = !shamt[i]          ? stage_s[i] :
                          (dir == DIR_LEFT)  ? rotl_s     :
                                               rotr_s;
  end : g_stage

  assign rot = stage_s[SHAMT_WIDTH];

endmodule : barrel_rotate_core

// File: rtl/barrel_shifter_top.sv
// -----------------------------------------------------------------------------
// barrel_shifter_top
// Registered rotate unit: barrel_rotate_core followed by one output register
// stage with a single-cycle valid pulse. One result per cycle, no
// backpressure, latency one cycle. Outputs come straight from flops.
//
// Ports:
//   clk        in  1            clock, rising edge
//   rst_n      in  1            synchronous active-low reset
//   in_valid   in  1            qualifies a_in / shamt / dir
//   a_in       in  WIDTH        word to rotate
//   shamt      in  SHAMT_WIDTH  rotate amount
//   dir        in  1            0 = left, 1 = right
//   out_valid  out 1            a_out carries a new result this cycle
//   a_out      out WIDTH        registered rotate result (held when idle)
// -----------------------------------------------------------------------------
module barrel_shifter_top
  import barrel_pkg::*;
#(
  parameter  int WIDTH       = 16,
  localparam int SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       a_in,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   dir,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       a_out
);

  logic [WIDTH-1:0] rot_s;
  logic [WIDTH-1:0] a_out_d;
  logic [WIDTH-1:0] a_out_q;
  logic             out_valid_d;
  logic             out_valid_q;

  barrel_rotate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_in  (a_in),
    .shamt (shamt),
    .dir   (dir),
    .rot   (rot_s)
  );

  // Next state: capture a new result on a valid input; otherwise hold the
  // data word and drop valid.
  always_comb begin
    a_out_d     = a_out_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      a_out_d     = rot_s;
      out_valid_d = 1'b1;
    end else begin
      a_out_d     = a_out_q;
      out_valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset; reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out_q     <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      a_out_q     <= a_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign a_out     = a_out_q;
  assign out_valid = out_valid_q;

endmodule : barrel_shifter_top

// File: tb/tb_barrel_shifter_top.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter_top
// Scoreboard bench: every driven cycle pushes the expected (out_valid, a_out)
// for the following edge; a monitor pops and compares one cycle later.
// Directed vectors carry literal expectations; random vectors use an
// arithmetic reference rotate.
// -----------------------------------------------------------------------------
module tb_barrel_shifter_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a_in;
  logic [3:0]  shamt;
  logic        dir;
  logic        out_valid;
  logic [15:0] a_out;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [15:0] a;
    logic [3:0]  s;
    logic        dr;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_a = 16'h0000;
  int          total   = 0;
  int          bad     = 0;

  always #5 clk = ~clk;

  barrel_shifter_top #(
    .WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a_in      (a_in),
    .shamt     (shamt),
    .dir       (dir),
    .out_valid (out_valid),
    .a_out     (a_out)
  );

  // Reference rotate straight from the shift-or formulas.
  function automatic logic [15:0] rot_ref(input logic [15:0] a, input int s, input logic d);
    logic [31:0] x;
    x = {16'h0000, a};
    if (s == 0) return a;
    if (d == 1'b0) x = (x << s) | (x >> (16 - s));
    else           x = (x >> s) | (x << (16 - s));
    return x[15:0];
  endfunction

  // Drive one cycle of stimulus and push what the next edge must produce.
  task automatic drive(input logic r, input logic v, input logic [15:0] a,
                       input logic [3:0] s, input logic d,
                       input logic use_lit, input logic [15:0] lit, input string tag);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n    = r;
    in_valid = v;
    a_in     = a;
    shamt    = s;
    dir      = d;
    if (!r) begin
      model_a = 16'h0000;
      e.v     = 1'b0;
    end else if (v) begin
      model_a = use_lit ? lit : rot_ref(a, int'(s), d);
      e.v     = 1'b1;
    end else begin
      e.v     = 1'b0;
    end
    e.d   = model_a;
    e.a   = a;
    e.s   = s;
    e.dr  = d;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: one cycle after each driven cycle, compare DUT against the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (out_valid !== e.v) begin
          bad++;
          $display("FAIL %s out_valid: act=%b exp=%b", e.tag, out_valid, e.v);
        end
        total++;
        if (a_out !== e.d) begin
          bad++;
          $display("FAIL %s a_out: a_in=%h shamt=%0d dir=%b exp=%h act=%h",
                   e.tag, e.a, e.s, e.dr, e.d, a_out);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] ra;
    logic [3:0]  rs;
    logic        rd;
    logic        rv;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a_in     = 16'h0000;
    shamt    = 4'd0;
    dir      = 1'b0;

    // Reset held for three cycles with a valid input present.
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 16'hFFFF, 4'd3, 1'b0, 1'b0, 16'h0000, "reset");

    // Basic rotates, first one straight after reset release.
    drive(1'b1, 1'b1, 16'h1234, 4'd4, 1'b0, 1'b1, 16'h2341, "rotl4");
    drive(1'b1, 1'b1, 16'h1234, 4'd4, 1'b1, 1'b1, 16'h4123, "rotr4");

    // Boundaries with a valid/valid/idle/valid handshake pattern.
    drive(1'b1, 1'b1, 16'h8001, 4'd15, 1'b0, 1'b1, 16'hC000, "rotl15");
    drive(1'b1, 1'b1, 16'h8001, 4'd15, 1'b1, 1'b1, 16'h0003, "rotr15");
    drive(1'b1, 1'b0, 16'h5A5A, 4'd7,  1'b0, 1'b0, 16'h0000, "gap_hold");
    drive(1'b1, 1'b1, 16'hA5C3, 4'd0,  1'b0, 1'b1, 16'hA5C3, "zero_l");
    drive(1'b1, 1'b1, 16'hA5C3, 4'd0,  1'b1, 1'b1, 16'hA5C3, "zero_r");

    // Reset mid-stream: accepted result, then reset discards the next one.
    drive(1'b1, 1'b1, 16'h0F0F, 4'd3, 1'b0, 1'b0, 16'h0000, "pre_rst");
    drive(1'b0, 1'b1, 16'hBEEF, 4'd5, 1'b1, 1'b0, 16'h0000, "mid_rst");
    drive(1'b0, 1'b0, 16'h1111, 4'd1, 1'b0, 1'b0, 16'h0000, "rst_idle");
    drive(1'b1, 1'b1, 16'hC0DE, 4'd9, 1'b1, 1'b0, 16'h0000, "post_rst");

    // Random vectors, roughly one idle cycle in four.
    for (int i = 0; i < 48; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rs = 4'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      drive(1'b1, rv, ra, rs, rd, 1'b0, 16'h0000, "random");
    end

    drive(1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 16'h0000, "drain");
    @(posedge clk);
    #3;

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: act=%0d entries left exp=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_barrel_shifter_top
